// File: rtl/utopia_phy_cell_source.sv
// PHY-side Utopia L1 cell source: loader fills Depth cell slots; cells stream out on data/soc when en is low.
// clav rises one edge after a cell completes; en high pauses the stream; loader bytes are dropped (wr_err) when full.
module utopia_phy_cell_source #(
    parameter int IfWidth   = 8,
    parameter int CellBytes = 53,
    parameter int Depth     = 2
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               wr_en,
    input  logic               wr_soc,
    input  logic [IfWidth-1:0] wr_data,
    output logic               wr_full,
    output logic               wr_err,
    input  logic               en,
    output logic [IfWidth-1:0] data,
    output logic               soc,
    output logic               clav
);

    localparam int SW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int BW = (CellBytes > 1) ? $clog2(CellBytes) : 1;
    localparam int CW = $clog2(Depth + 1);
    localparam logic [BW-1:0] LAST = BW'(CellBytes - 1);

    typedef logic [SW-1:0] slot_t;
    typedef logic [BW-1:0] idx_t;
    typedef logic [CW-1:0] cnt_t;

    typedef enum logic {W_IDLE, W_FILL} w_state_t;
    typedef enum logic {R_IDLE, R_SEND} r_state_t;

    logic [IfWidth-1:0] mem [Depth][CellBytes];

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;
    slot_t    wslot, wslot_next, rslot, rslot_next;
    idx_t     widx, widx_next, ridx, ridx_next, mem_widx;
    cnt_t     ready_cnt, ready_next, used_cnt, used_next;
    logic     mem_we, err_next, cell_done, cell_start, slot_free;
    logic [IfWidth-1:0] data_next;
    logic     soc_next;

    function automatic slot_t slot_inc(input slot_t s);
        return (s == SW'(Depth - 1)) ? '0 : s + SW'(1);
    endfunction

    assign wr_full = (used_cnt == CW'(Depth));

    // Loader side. A partial cell never occupies a counted slot, so wr_full
    // can only be seen from W_IDLE.
    always_comb begin
        w_state_next = w_state;
        wslot_next   = wslot;
        widx_next    = widx;
        mem_we       = 1'b0;
        mem_widx     = widx;
        err_next     = 1'b0;
        cell_done    = 1'b0;
        if (wr_en) begin
            if (wr_full) begin
                err_next = 1'b1;
            end else if (wr_soc) begin
                mem_we       = 1'b1;
                mem_widx     = '0;
                widx_next    = BW'(1);
                w_state_next = W_FILL;
                err_next     = (w_state == W_FILL);
            end else if (w_state == W_IDLE) begin
                err_next = 1'b1;
            end else begin
                mem_we = 1'b1;
                if (widx == LAST) begin
                    cell_done    = 1'b1;
                    widx_next    = '0;
                    wslot_next   = slot_inc(wslot);
                    w_state_next = W_IDLE;
                end else begin
                    widx_next = widx + BW'(1);
                end
            end
        end
    end

    // Output side. The edge after byte 52 frees the slot and may start the
    // next ready cell on the same edge, so back-to-back cells have no gap.
    always_comb begin
        r_state_next = r_state;
        rslot_next   = rslot;
        ridx_next    = ridx;
        data_next    = data;
        soc_next     = soc;
        cell_start   = 1'b0;
        slot_free    = 1'b0;
        if (!en) begin
            case (r_state)
                R_IDLE: begin
                    if (ready_cnt != '0) begin
                        data_next    = mem[rslot][0];
                        soc_next     = 1'b1;
                        ridx_next    = '0;
                        cell_start   = 1'b1;
                        r_state_next = R_SEND;
                    end
                end
                R_SEND: begin
                    if (ridx != LAST) begin
                        data_next = mem[rslot][ridx + BW'(1)];
                        soc_next  = 1'b0;
                        ridx_next = ridx + BW'(1);
                    end else begin
                        slot_free    = 1'b1;
                        rslot_next   = slot_inc(rslot);
                        soc_next     = 1'b0;
                        r_state_next = R_IDLE;
                        if (ready_cnt != '0) begin
                            data_next    = mem[slot_inc(rslot)][0];
                            soc_next     = 1'b1;
                            ridx_next    = '0;
                            cell_start   = 1'b1;
                            r_state_next = R_SEND;
                        end
                    end
                end
                default: r_state_next = R_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_next = ready_cnt;
        if (cell_done && !cell_start)
            ready_next = ready_cnt + CW'(1);
        else if (!cell_done && cell_start)
            ready_next = ready_cnt - CW'(1);
        used_next = used_cnt;
        if (cell_done && !slot_free)
            used_next = used_cnt + CW'(1);
        else if (!cell_done && slot_free)
            used_next = used_cnt - CW'(1);
    end

    always_ff @(posedge clk_in) begin
        if (!reset && mem_we)
            mem[wslot][mem_widx] <= wr_data;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            wslot     <= '0;
            widx      <= '0;
            rslot     <= '0;
            ridx      <= '0;
            ready_cnt <= '0;
            used_cnt  <= '0;
            data      <= '0;
            soc       <= 1'b0;
            clav      <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            w_state   <= w_state_next;
            r_state   <= r_state_next;
            wslot     <= wslot_next;
            widx      <= widx_next;
            rslot     <= rslot_next;
            ridx      <= ridx_next;
            ready_cnt <= ready_next;
            used_cnt  <= used_next;
            data      <= data_next;
            soc       <= soc_next;
            clav      <= (ready_cnt != '0);
            wr_err    <= err_next;
        end
    end

endmodule
